// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with optional hardwired zero entry and a sequential clear engine.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [NUM_RD*XLEN-1:0]   rd_data_o,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [XLEN-1:0]          wr_data_i,
    output logic                     busy_o
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam bit          ZeroEn = (ZERO_REG != 0);

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StReady = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic [XLEN-1:0] mem_q [DEPTH];
    logic            clearing;
    logic            wr_fire;

    assign clearing = (state_q == StClear);
    // Held reset also reports busy, before the first edge has moved the FSM.
    assign busy_o   = reset_i | clearing;
    assign wr_fire  = ~reset_i & (state_q == StReady) & we_i &
                      ~(ZeroEn && (wr_addr_i == '0));

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == StClear) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == AW'(DEPTH - 1)) begin
                state_d = StReady;
            end
        end else if (clear_i) begin
            state_d   = StClear;
            clr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Storage has no reset; the clear engine zeroes it one entry per cycle.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (clearing) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (wr_fire) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] data;
            addr = rd_addr_i[k*AW +: AW];
            data = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_fire && (wr_addr_i == addr)) begin
                data = wr_data_i;
            end
`endif
            if (busy_o || (ZeroEn && (addr == '0))) begin
                data = '0;
            end
            rd_data_o[k*XLEN +: XLEN] = data;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: scoreboarded per-cycle reads, vector table, clear/reset sequences.
module tb_regfile_mp;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   clear;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic                   we;
    logic [AW-1:0]          wr_addr;
    logic [XLEN-1:0]        wr_data;
    logic                   busy;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(1)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .clear_i  (clear),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data),
        .we_i     (we),
        .wr_addr_i(wr_addr),
        .wr_data_i(wr_data),
        .busy_o   (busy)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        busy;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        w;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare outputs at the falling edge, advance past the rising edge.
    task automatic step(input string name, input logic rst, input logic clr, input logic w,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] e0, input logic [31:0] e1, input logic eb);
        exp_t e;
        e.d0 = e0;
        e.d1 = e1;
        e.busy = eb;
        sb.push_back(e);
        reset   = rst;
        clear   = clr;
        we      = w;
        wr_addr = wa;
        wr_data = wd;
        rd_addr = {a1, a0};
        @(negedge clk);
        e = sb.pop_front();
        chk({name, " d0"}, rd_data[31:0], e.d0);
        chk({name, " d1"}, rd_data[63:32], e.d1);
        chk({name, " busy"}, {31'b0, busy}, {31'b0, e.busy});
        @(posedge clk);
        #1;
    endtask

    // Count falling edges with busy high; inputs are whatever the caller left driven.
    task automatic count_busy(input string name, input int exp_n);
        int n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) begin
                n++;
            end else begin
                we    = 1'b0;
                clear = 1'b0;
                break;
            end
        end
        chk(name, 32'(n), 32'(exp_n));
        @(posedge clk);
        #1;
    endtask

    task automatic read_all_zero(input string name);
        for (int a = 0; a < DEPTH; a++) begin
            step(name, 0, 0, 0, 0, 0, 5'(a), 5'(DEPTH - 1 - a), 0, 0, 0);
        end
    endtask

    initial begin
        vecs[0] = '{1, 5,  32'hDEADBEEF, 5,  5,  Byp ? 32'hDEADBEEF : 32'h0,
                    Byp ? 32'hDEADBEEF : 32'h0};
        vecs[1] = '{0, 0,  32'h0,        5,  5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1, 0,  32'h12345678, 0,  0,  32'h0, 32'h0};
        vecs[3] = '{0, 0,  32'h0,        0,  5,  32'h0, 32'hDEADBEEF};
        vecs[4] = '{1, 7,  32'h11111111, 7,  5,  Byp ? 32'h11111111 : 32'h0, 32'hDEADBEEF};
        vecs[5] = '{1, 7,  32'hA5A5A5A5, 7,  7,  Byp ? 32'hA5A5A5A5 : 32'h11111111,
                    Byp ? 32'hA5A5A5A5 : 32'h11111111};
        vecs[6] = '{0, 0,  32'h0,        7,  0,  32'hA5A5A5A5, 32'h0};
        vecs[7] = '{1, 31, 32'hFFFFFFFF, 31, 30, Byp ? 32'hFFFFFFFF : 32'h0, 32'h0};
        vecs[8] = '{0, 0,  32'h0,        30, 31, 32'h0, 32'hFFFFFFFF};
        vecs[9] = '{1, 1,  32'h00000001, 2,  1,  32'h0, Byp ? 32'h1 : 32'h0};

        reset = 1'b1; clear = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        @(posedge clk);
        #1;

        // Reset state and initial clear length
        for (int i = 0; i < 3; i++) step("reset", 1, 0, 1, 5, 32'h55, 5, 0, 0, 0, 1);
        reset = 1'b0;
        count_busy("init_busy_len", 32);
        read_all_zero("init_zero");

        for (int i = 0; i < 10; i++) begin
            step($sformatf("vec%0d", i), 0, 0, vecs[i].w, vecs[i].wa, vecs[i].wd,
                 vecs[i].a0, vecs[i].a1, vecs[i].e0, vecs[i].e1, 0);
        end

        // Fill 1..31 with index, reading back the previous entry
        for (int i = 1; i < DEPTH; i++) begin
            step("fill", 0, 0, 1, 5'(i), 32'(i), 5'(i - 1), 0,
                 (i == 1) ? 32'h0 : 32'(i - 1), 0, 0);
        end
        step("fill_rd", 0, 0, 0, 0, 0, 5, 31, 32'd5, 32'd31, 0);
        step("clear_pulse", 0, 1, 1, 3, 32'h333, 5, 3, 32'd5, Byp ? 32'h333 : 32'd3, 0);
        step("busy_mask", 0, 1, 1, 9, 32'h999, 5, 9, 0, 0, 1);
        we = 1'b1; wr_addr = 5'd9; wr_data = 32'h999; clear = 1'b1;
        count_busy("clear_busy_len", 31);
        read_all_zero("post_clear_zero");

        // Reset in the middle of a clear restarts it from entry 0
        step("wr4", 0, 0, 1, 4, 32'd44, 0, 0, 0, 0, 0);
        step("clr2_pulse", 0, 1, 0, 0, 0, 4, 0, 32'd44, 0, 0);
        for (int i = 0; i < 10; i++) step("clr2_busy", 0, 0, 0, 0, 0, 4, 4, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("mid_reset", 1, 0, 1, 4, 32'h77, 4, 0, 0, 0, 1);
        reset = 1'b0;
        count_busy("restart_busy_len", 32);
        step("restart_rd4", 0, 0, 1, 6, 32'd66, 4, 6, 0, Byp ? 32'd66 : 32'h0, 0);
        step("post_rd6", 0, 0, 0, 0, 0, 6, 6, 32'd66, 32'd66, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
